// File: rtl/fp_alu_result_stage.sv
// fp_alu_result_stage
// Registered output stage behind the floating-point ALU. Buffers each result
// with its opcode and ALU flags in a small FIFO, classifies the result as
// inf/nan on entry, and keeps sticky status flags plus saturating counters.
module fp_alu_result_stage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic [1:0]       in_func,
    input  logic             in_overflow,
    input  logic             in_underflow,
    input  logic             in_exception,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [1:0]       out_func,
    output logic [4:0]       out_flags,
    input  logic             clear_sticky,
    output logic [2:0]       sticky_flags,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] exc_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]      res_mem_q  [DEPTH];
    logic [1:0]       func_mem_q [DEPTH];
    logic [4:0]       flag_mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [2:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0] exc_cnt_q, exc_cnt_d;

    logic             push, pop;
    logic [7:0]       in_exp;
    logic [22:0]      in_mant;
    logic             in_inf, in_nan, in_any_flag;
    logic [4:0]       in_flags;

    // Handshake qualifiers and result classification at push time.
    always_comb begin
        in_ready    = (count_q != CW'(DEPTH));
        out_valid   = (count_q != '0);
        push        = in_valid && in_ready;
        pop         = out_valid && out_ready;
        in_exp      = in_result[30:23];
        in_mant     = in_result[22:0];
        in_inf      = (in_exp == 8'hFF) && (in_mant == '0);
        in_nan      = (in_exp == 8'hFF) && (in_mant != '0);
        in_any_flag = in_exception || in_underflow || in_overflow;
        in_flags    = {in_nan, in_inf, in_exception, in_underflow, in_overflow};
    end

    // Next-state for pointers, occupancy, sticky flags and counters.
    // A clear in the same cycle as a push starts from zero, then adds the push.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        sticky_d  = sticky_q;
        op_cnt_d  = op_cnt_q;
        exc_cnt_d = exc_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        if (clear_sticky) begin
            sticky_d  = '0;
            op_cnt_d  = '0;
            exc_cnt_d = '0;
        end
        if (push) begin
            sticky_d = sticky_d | {in_exception, in_underflow, in_overflow};
            if (op_cnt_d != '1) op_cnt_d = op_cnt_d + CNT_W'(1);
            if (in_any_flag && (exc_cnt_d != '1)) exc_cnt_d = exc_cnt_d + CNT_W'(1);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sticky_q  <= '0;
            op_cnt_q  <= '0;
            exc_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            sticky_q  <= sticky_d;
            op_cnt_q  <= op_cnt_d;
            exc_cnt_q <= exc_cnt_d;
        end
    end

    // FIFO storage write; contents are don't-care until referenced by count.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            res_mem_q[wr_ptr_q]  <= in_result;
            func_mem_q[wr_ptr_q] <= in_func;
            flag_mem_q[wr_ptr_q] <= in_flags;
        end
    end

    // Head entry outputs, forced to zero while empty.
    always_comb begin
        out_result   = '0;
        out_func     = '0;
        out_flags    = '0;
        if (out_valid) begin
            out_result = res_mem_q[rd_ptr_q];
            out_func   = func_mem_q[rd_ptr_q];
            out_flags  = flag_mem_q[rd_ptr_q];
        end
        sticky_flags = sticky_q;
        op_count     = op_cnt_q;
        exc_count    = exc_cnt_q;
    end

endmodule

// File: tb/tb_fp_alu_result_stage.sv
// Testbench for fp_alu_result_stage: directed and random stimulus checked
// against a queue-based reference model. A second instance with 2-bit
// counters shares the stimulus to exercise counter saturation.
module tb_fp_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, clear_sticky;
    logic        in_overflow, in_underflow, in_exception;
    logic [31:0] in_result;
    logic [1:0]  in_func;

    logic        in_ready, out_valid;
    logic [31:0] out_result;
    logic [1:0]  out_func;
    logic [4:0]  out_flags;
    logic [2:0]  sticky_flags;
    logic [15:0] op_count, exc_count;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_result;
    logic [1:0]  s_out_func;
    logic [4:0]  s_out_flags;
    logic [2:0]  s_sticky_flags;
    logic [1:0]  s_op_count, s_exc_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] result;
        logic [1:0]  func;
        logic [4:0]  flags;
    } entry_t;

    entry_t      mq[$];
    logic [2:0]  m_sticky;
    int unsigned m_op, m_exc, m_op2, m_exc2;

    always #5 clk = ~clk;

    fp_alu_result_stage #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_func(in_func), .in_overflow(in_overflow),
        .in_underflow(in_underflow), .in_exception(in_exception),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_func(out_func), .out_flags(out_flags), .clear_sticky(clear_sticky),
        .sticky_flags(sticky_flags), .op_count(op_count), .exc_count(exc_count)
    );

    fp_alu_result_stage #(.DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_result(in_result), .in_func(in_func), .in_overflow(in_overflow),
        .in_underflow(in_underflow), .in_exception(in_exception),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
        .out_func(s_out_func), .out_flags(s_out_flags), .clear_sticky(clear_sticky),
        .sticky_flags(s_sticky_flags), .op_count(s_op_count), .exc_count(s_exc_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Classification from the IEEE single-precision field definitions.
    function automatic logic [4:0] classify(input logic [31:0] r, input logic exc,
                                            input logic unf, input logic ovf);
        int unsigned e, m;
        e = (r / 32'd8388608) % 256;
        m = r % 32'd8388608;
        return {(e == 255 && m != 0), (e == 255 && m == 0), exc, unf, ovf};
    endfunction

    // Advance one clock, update the model with the handshake that occurred, check outputs.
    task automatic step();
        bit acc, pp, anyf;
        entry_t e;
        acc  = in_valid && (mq.size() < 4);
        pp   = out_ready && (mq.size() > 0);
        anyf = in_exception | in_underflow | in_overflow;
        e.result = in_result;
        e.func   = in_func;
        e.flags  = classify(in_result, in_exception, in_underflow, in_overflow);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_sticky = 3'b000; m_op = 0; m_exc = 0; m_op2 = 0; m_exc2 = 0;
        end else begin
            if (pp) void'(mq.pop_front());
            if (clear_sticky) begin
                m_sticky = 3'b000; m_op = 0; m_exc = 0; m_op2 = 0; m_exc2 = 0;
            end
            if (acc) begin
                mq.push_back(e);
                m_sticky = m_sticky | {in_exception, in_underflow, in_overflow};
                if (m_op  < 65535) m_op++;
                if (m_op2 < 3)     m_op2++;
                if (anyf && m_exc  < 65535) m_exc++;
                if (anyf && m_exc2 < 3)     m_exc2++;
            end
        end
        #1;
        check("in_ready",     in_ready,     mq.size() < 4);
        check("out_valid",    out_valid,    mq.size() > 0);
        check("out_result",   out_result,   mq.size() > 0 ? mq[0].result : 32'h0);
        check("out_func",     out_func,     mq.size() > 0 ? mq[0].func   : 2'h0);
        check("out_flags",    out_flags,    mq.size() > 0 ? mq[0].flags  : 5'h0);
        check("sticky_flags", sticky_flags, m_sticky);
        check("op_count",     op_count,     m_op);
        check("exc_count",    exc_count,    m_exc);
        check("sat_op_count", s_op_count,   m_op2);
        check("sat_exc_count", s_exc_count, m_exc2);
        check("sat_out_result", s_out_result, out_result);
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [1:0] f,
                         input logic ovf, input logic unf, input logic exc,
                         input logic rdy, input logic clr);
        in_valid = v; in_result = r; in_func = f;
        in_overflow = ovf; in_underflow = unf; in_exception = exc;
        out_ready = rdy; clear_sticky = clr;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 32'h0, 2'd0, 0, 0, 0, 0, 0);
        m_sticky = 3'b000; m_op = 0; m_exc = 0; m_op2 = 0; m_exc2 = 0;
        step(); step();
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        rst = 1'b0;

        // Single push then pop.
        drive(1, 32'h40400000, 2'd0, 0, 0, 0, 0, 0);
        step();
        check("single_result", out_result, 32'h40400000);
        check("single_op_count", op_count, 16'd1);
        drive(0, 32'h0, 2'd0, 0, 0, 0, 1, 0);
        step();
        check("single_popped", out_valid, 1'b0);

        // Fill to full with the consumer stalled; fifth offer is refused.
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h3F800000 + 32'(i), 2'(i), 0, 0, 0, 0, 0);
            step();
        end
        check("full_in_ready", in_ready, 1'b0);
        check("full_op_count", op_count, 16'd5);
        drive(0, 32'h0, 2'd0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step();
        check("drained", out_valid, 1'b0);

        // Streaming push+pop every cycle.
        for (int i = 0; i < 20; i++) begin
            drive(1, $urandom, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1, 0);
            step();
        end
        drive(0, 32'h0, 2'd0, 0, 0, 0, 1, 0);
        step();

        // Inf and NaN classification with fresh sticky state.
        drive(0, 32'h0, 2'd0, 0, 0, 0, 0, 1);
        step();
        drive(1, 32'h7F800000, 2'd2, 1, 0, 0, 0, 0);
        step();
        check("inf_flags", out_flags, 5'b01001);
        drive(1, 32'hFFFFFFFF, 2'd3, 0, 0, 1, 1, 0);
        step();
        check("nan_flags", out_flags, 5'b10100);
        check("inf_nan_sticky", sticky_flags, 3'b101);
        check("inf_nan_exc_count", exc_count, 16'd2);
        drive(0, 32'h0, 2'd0, 0, 0, 0, 1, 0);
        step();

        // Clear coincident with a push: the push contribution survives.
        drive(1, 32'h00000001, 2'd1, 0, 1, 0, 1, 1);
        step();
        check("clr_push_sticky", sticky_flags, 3'b010);
        check("clr_push_op", op_count, 16'd1);
        check("clr_push_exc", exc_count, 16'd1);

        // Saturation of the 2-bit counters.
        drive(0, 32'h0, 2'd0, 0, 0, 0, 1, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h40000000, 2'd0, 0, 0, 0, 1, 0);
            step();
        end
        check("sat_op_count_3", s_op_count, 2'd3);

        // Random mixed traffic.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0) ? 32'h7F800000 | 32'($urandom_range(0, 1)) : $urandom,
                  2'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0));
            step();
        end

        // Reset with entries queued and sticky set.
        drive(0, 32'h0, 2'd0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h41000000 + 32'(i), 2'd2, 1, 1, 1, 0, 0);
            step();
        end
        drive(1, 32'h42000000, 2'd1, 1, 0, 0, 1, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 32'h0, 2'd0, 0, 0, 0, 0, 0);
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);
        check("post_rst_sticky", sticky_flags, 3'b000);
        check("post_rst_op_count", op_count, 16'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_alu_result_stage.md
# fp_alu_result_stage

Registered downstream stage for the combinational floating-point ALU. It captures each ALU result together with its opcode and its overflow/underflow/exception flags into a small FIFO, and hands them out over a valid/ready interface. It also keeps IEEE-style sticky status flags and saturating event counters for software to read. It sits directly after the ALU output mux, so consumers never see combinational ALU paths.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- CNT_W, 16, width of each saturating counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ALU output is valid this cycle
- in_ready  out  1  stage can accept (FIFO not full)
- in_result  in  32  ALU result word
- in_func  in  2  opcode that produced it: 00 add, 01 sub, 10 mul, 11 div
- in_overflow  in  1  ALU overflow flag
- in_underflow  in  1  ALU underflow flag
- in_exception  in  1  ALU exception flag
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head entry
- out_result  out  32  head result; 0 when empty
- out_func  out  2  head opcode; 0 when empty
- out_flags  out  5  head {nan, inf, exception, underflow, overflow}; 0 when empty
- clear_sticky  in  1  clear sticky flags and counters
- sticky_flags  out  3  {exception, underflow, overflow} accumulated
- op_count  out  CNT_W  accepted operations, saturating
- exc_count  out  CNT_W  accepted entries with any of the 3 ALU flags set, saturating

## Operation
- Push: when in_valid && in_ready, write {in_result, in_func, derived flags} at wr_ptr; wr_ptr+1 mod DEPTH; count+1.
- Derived flags are computed from in_result at push time:
  - inf = exp==8'hFF && mant==0
  - nan = exp==8'hFF && mant!=0
  - 32'hFFFFFFFF therefore classifies as nan.
- Pop: when out_valid && out_ready, rd_ptr+1 mod DEPTH; count-1.
- Occupancy: in_ready = (count != DEPTH); out_valid = (count != 0). count is $clog2(DEPTH)+1 bits wide.
- Push and pop in the same cycle:
  - Legal whenever 0 < count < DEPTH; count is unchanged and both pointers advance.
  - When full: in_ready=0, so pop only.
  - When empty: push only; there is no bypass.
- Outputs are driven from the head entry, gated to 0 when count==0.
- Sticky flags: on each accepted push, sticky_flags |= {in_exception, in_underflow, in_overflow}. Popping does not affect sticky state.
- Counters: on each accepted push, op_count increments, saturating at 2^CNT_W-1. exc_count increments, also saturating, if any ALU flag is set.
- clear_sticky: zeroes sticky_flags, op_count and exc_count on the next edge. If an accepted push happens in the same cycle, the push wins: the result is the cleared value plus that push's contribution (sticky = that push's flags, op_count=1, exc_count=0 or 1). clear_sticky does not touch FIFO contents.
- in_valid while in_ready=0: ignored. The producer holds its data; the stage never drops an accepted entry.

## Timing
- Reset values (rst high at an edge): count=0, wr_ptr=rd_ptr=0, in_ready=1, out_valid=0, out_result=0, out_func=0, out_flags=0, sticky_flags=0, op_count=0, exc_count=0. FIFO storage need not be cleared.
- Reset mid-operation discards all queued entries and counters; it overrides push, pop and clear_sticky in that cycle.
- Latency: an entry pushed at edge N gives out_valid=1 with its data after edge N (visible in cycle N+1).
- Throughput: one push and one pop per cycle with no bubbles.
- in_ready and out_valid are pure functions of registered count; there is no combinational path from out_ready to in_ready.
- Sticky and counter outputs update at the same edge as the push that causes them.

## Test plan
- Reset then single push of in_result=32'h40400000, func=00, flags 0 → next cycle out_valid=1, out_result=32'h40400000, out_flags=0; op_count=1; pop with out_ready=1 → out_valid=0, outputs 0.
- DEPTH=4 with out_ready=0: push 5 times → in_ready=0 after 4th accept, 5th not accepted, op_count=4. Then pop all → values come out in order, count returns to 0.
- Steady stream with in_valid=out_ready=1 for 20 cycles → one result per cycle, count stays 1, no loss or duplication, order preserved.
- Push in_result=32'h7F800000 with overflow=1, then push 32'hFFFFFFFF with exception=1:
  - out_flags are 5'b00001|inf (5'b01001), then 5'b10100.
  - sticky_flags=3'b101, exc_count=2.
- Assert clear_sticky together with an accepted push carrying underflow=1 → next cycle sticky_flags=3'b010, op_count=1, exc_count=1. With CNT_W=2, 5 clean pushes → op_count saturates at 3.
- Assert rst for one cycle with 3 entries queued and sticky set → next cycle every output matches its reset value and in_ready=1.
